// File: rtl/game_speed_ctrl.sv
// Game-rate controller feeding the game-tick timer: run state, level, elapsed ticks,
// and the dividend/enable/reload controls for the downstream timer.
module game_speed_ctrl #(
  parameter int BASE_RATE      = 1,
  parameter int RATE_STEP      = 1,
  parameter int MAX_LEVEL      = 9,
  parameter int HITS_PER_LEVEL = 5
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        start,
  input  logic        pause,
  input  logic        game_over,
  input  logic        hit,
  input  logic        tick,
  output logic [25:0] dividend,
  output logic        timer_enable,
  output logic        timer_resetn,
  output logic [3:0]  level,
  output logic [15:0] elapsed,
  output logic        running,
  output logic        over
);

  localparam int HIT_W = (HITS_PER_LEVEL > 1) ? $clog2(HITS_PER_LEVEL) : 1;
  localparam logic [HIT_W-1:0] HIT_LAST  = HIT_W'(HITS_PER_LEVEL - 1);
  localparam logic [3:0]       LEVEL_MAX = 4'(MAX_LEVEL);
  localparam logic [25:0]      BASE_W    = 26'(BASE_RATE);
  localparam logic [25:0]      STEP_W    = 26'(RATE_STEP);

  typedef enum logic [1:0] {IDLE, RUN, PAUSED, OVER} state_t;

  state_t            state_reg, state_next;
  logic [3:0]        level_reg, level_next;
  logic [HIT_W-1:0]  hit_cnt_reg, hit_cnt_next;
  logic [15:0]       elapsed_reg, elapsed_next;
  logic [25:0]       dividend_reg, dividend_next;
  logic              reload_next;
  logic              timer_resetn_reg, timer_enable_reg, running_reg, over_reg;

  always_comb begin
    state_next   = state_reg;
    level_next   = level_reg;
    hit_cnt_next = hit_cnt_reg;
    elapsed_next = elapsed_reg;
    reload_next  = 1'b0;

    if (start) begin
      state_next   = RUN;
      level_next   = 4'd0;
      hit_cnt_next = '0;
      elapsed_next = 16'd0;
      reload_next  = 1'b1;
    end else begin
      case (state_reg)
        RUN: begin
          if (game_over) begin
            state_next = OVER;
          end else if (pause) begin
            state_next = PAUSED;
          end else begin
            if (tick && elapsed_reg != 16'hFFFF)
              elapsed_next = elapsed_reg + 16'd1;
            if (hit) begin
              if (hit_cnt_reg == HIT_LAST) begin
                hit_cnt_next = '0;
                // At the top level the hit counter still wraps, but the timer keeps its rate.
                if (level_reg < LEVEL_MAX) begin
                  level_next  = level_reg + 4'd1;
                  reload_next = 1'b1;
                end
              end else begin
                hit_cnt_next = hit_cnt_reg + 1'b1;
              end
            end
          end
        end
        PAUSED: begin
          if (game_over)
            state_next = OVER;
          else if (!pause)
            state_next = RUN;
        end
        default: ;
      endcase
    end

    dividend_next = BASE_W + 26'(level_next) * STEP_W;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_reg        <= IDLE;
      level_reg        <= 4'd0;
      hit_cnt_reg      <= '0;
      elapsed_reg      <= 16'd0;
      dividend_reg     <= BASE_W;
      timer_resetn_reg <= 1'b0;
      timer_enable_reg <= 1'b0;
      running_reg      <= 1'b0;
      over_reg         <= 1'b0;
    end else begin
      state_reg        <= state_next;
      level_reg        <= level_next;
      hit_cnt_reg      <= hit_cnt_next;
      elapsed_reg      <= elapsed_next;
      dividend_reg     <= dividend_next;
      // Low for exactly the cycle after a restart or level-up so the timer reloads.
      timer_resetn_reg <= ~reload_next;
      timer_enable_reg <= (state_next == RUN);
      running_reg      <= (state_next == RUN);
      over_reg         <= (state_next == OVER);
    end
  end

  assign dividend     = dividend_reg;
  assign timer_enable = timer_enable_reg;
  assign timer_resetn = timer_resetn_reg;
  assign level        = level_reg;
  assign elapsed      = elapsed_reg;
  assign running      = running_reg;
  assign over         = over_reg;

endmodule

// File: tb/tb_game_speed_ctrl.sv
// Randomised bench for game_speed_ctrl with a behavioural model and per-cycle comparison.
module tb_game_speed_ctrl;

  localparam int BASE = 1, STEP = 1, MAXL = 9, HPL = 5;
  localparam int S_IDLE = 0, S_RUN = 1, S_PAUSE = 2, S_OVER = 3;

  logic        clk, resetn;
  logic        start, pause, game_over, hit, tick;
  logic [25:0] dividend;
  logic        timer_enable, timer_resetn, running, over;
  logic [3:0]  level;
  logic [15:0] elapsed;

  int n_vec = 0;
  int n_err = 0;

  game_speed_ctrl #(
    .BASE_RATE(BASE), .RATE_STEP(STEP), .MAX_LEVEL(MAXL), .HITS_PER_LEVEL(HPL)
  ) dut (
    .clk(clk), .resetn(resetn), .start(start), .pause(pause), .game_over(game_over),
    .hit(hit), .tick(tick), .dividend(dividend), .timer_enable(timer_enable),
    .timer_resetn(timer_resetn), .level(level), .elapsed(elapsed),
    .running(running), .over(over)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      if (n_err <= 40)
        $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: game state expressed as plain integers.
  int m_st, m_level, m_hits, m_elapsed;
  bit m_reload;

  always @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      m_st = S_IDLE; m_level = 0; m_hits = 0; m_elapsed = 0; m_reload = 1'b1;
    end else begin
      m_reload = 1'b0;
      if (start) begin
        m_st = S_RUN; m_level = 0; m_hits = 0; m_elapsed = 0; m_reload = 1'b1;
      end else if ((m_st == S_RUN || m_st == S_PAUSE) && game_over) begin
        m_st = S_OVER;
      end else if (m_st == S_RUN && pause) begin
        m_st = S_PAUSE;
      end else if (m_st == S_PAUSE) begin
        if (!pause) m_st = S_RUN;
      end else if (m_st == S_RUN) begin
        if (tick) m_elapsed = (m_elapsed < 65535) ? m_elapsed + 1 : 65535;
        if (hit) begin
          m_hits = m_hits + 1;
          if (m_hits == HPL) begin
            m_hits = 0;
            if (m_level < MAXL) begin
              m_level = m_level + 1;
              m_reload = 1'b1;
            end
          end
        end
      end
    end
  end

  always @(negedge clk) begin
    chk("dividend", 32'(dividend), 32'(BASE + m_level * STEP));
    chk("timer_enable", 32'(timer_enable), 32'(m_st == S_RUN));
    chk("timer_resetn", 32'(timer_resetn), 32'(!m_reload));
    chk("level", 32'(level), 32'(m_level));
    chk("elapsed", 32'(elapsed), 32'(m_elapsed));
    chk("running", 32'(running), 32'(m_st == S_RUN));
    chk("over", 32'(over), 32'(m_st == S_OVER));
  end

  // Apply one cycle of inputs (called at a negedge) and return at the following negedge.
  task automatic cyc(input bit s, input bit p, input bit g, input bit h, input bit t);
    start = s; pause = p; game_over = g; hit = h; tick = t;
    @(negedge clk);
  endtask

  initial begin
    resetn = 1'b0;
    start = 0; pause = 0; game_over = 0; hit = 0; tick = 0;
    repeat (3) @(negedge clk);
    chk("rst_dividend", 32'(dividend), 32'd1);
    chk("rst_timer_resetn", 32'(timer_resetn), 32'd0);
    chk("rst_running", 32'(running), 32'd0);
    resetn = 1'b1;
    cyc(0, 0, 0, 1, 1);
    chk("idle_ignores", 32'(elapsed), 32'd0);
    chk("idle_timer_resetn", 32'(timer_resetn), 32'd1);

    cyc(1, 0, 0, 0, 0);
    chk("start_running", 32'(running), 32'd1);
    chk("start_enable", 32'(timer_enable), 32'd1);
    chk("start_dividend", 32'(dividend), 32'd1);
    chk("start_strobe", 32'(timer_resetn), 32'd0);
    cyc(0, 0, 0, 0, 0);
    chk("strobe_release", 32'(timer_resetn), 32'd1);

    for (int i = 0; i < 5; i++) cyc(0, 0, 0, 1, 0);
    chk("lvl1_level", 32'(level), 32'd1);
    chk("lvl1_dividend", 32'(dividend), 32'd2);
    chk("lvl1_strobe", 32'(timer_resetn), 32'd0);
    for (int i = 0; i < 45; i++) cyc(0, 0, 0, 1, 0);
    chk("max_level", 32'(level), 32'd9);
    chk("max_dividend", 32'(dividend), 32'd10);
    chk("max_no_strobe", 32'(timer_resetn), 32'd1);

    for (int i = 0; i < 7; i++) cyc(0, 0, 0, 0, 1);
    for (int i = 0; i < 100; i++) cyc(0, 1, 0, 1'($urandom), 1'($urandom));
    chk("pause_enable", 32'(timer_enable), 32'd0);
    chk("pause_elapsed", 32'(elapsed), 32'd7);
    cyc(0, 0, 0, 0, 0);
    chk("resume_running", 32'(running), 32'd1);

    cyc(0, 0, 1, 1, 0);
    chk("over_flag", 32'(over), 32'd1);
    chk("over_level", 32'(level), 32'd9);
    cyc(1, 0, 0, 0, 0);
    chk("restart_level", 32'(level), 32'd0);
    chk("restart_elapsed", 32'(elapsed), 32'd0);
    chk("restart_strobe", 32'(timer_resetn), 32'd0);

    for (int i = 0; i < 3000; i++) begin
      cyc(($urandom_range(0, 99) < 2), ($urandom_range(0, 9) < 2),
          ($urandom_range(0, 99) < 2), 1'($urandom), 1'($urandom));
    end

    cyc(1, 0, 0, 0, 0);
    for (int i = 0; i < 65534; i++) cyc(0, 0, 0, 0, 1);
    chk("sat_fffe", 32'(elapsed), 32'hFFFE);
    for (int i = 0; i < 3; i++) cyc(0, 0, 0, 0, 1);
    chk("sat_ffff", 32'(elapsed), 32'hFFFF);

    for (int i = 0; i < 6; i++) cyc(0, 0, 0, 1, 1);
    start = 0; hit = 0; tick = 0;
    @(posedge clk);
    #2 resetn = 1'b0;
    #1;
    chk("async_running", 32'(running), 32'd0);
    chk("async_level", 32'(level), 32'd0);
    chk("async_elapsed", 32'(elapsed), 32'd0);
    chk("async_dividend", 32'(dividend), 32'd1);
    chk("async_strobe", 32'(timer_resetn), 32'd0);
    @(negedge clk);
    resetn = 1'b1;
    cyc(0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
